// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline results with queued long-unit results onto the single
// register file write port, and keeps the long-write scoreboard that drives the ID hazard stall.
module wb_arbiter #(
   parameter int unsigned QDEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_valid_in,
   input  logic [4:0]  pipe_rd_addr_in,
   input  logic [31:0] pipe_rd_data_in,
   input  logic        lu_valid_in,
   input  logic [4:0]  lu_rd_addr_in,
   input  logic [31:0] lu_rd_data_in,
   output logic        lu_ready_out,
   input  logic        issue_valid_in,
   input  logic        issue_long_in,
   input  logic [4:0]  issue_rd_addr_in,
   input  logic [4:0]  rs1_addr_in,
   input  logic [4:0]  rs2_addr_in,
   output logic        hazard_stall_out,
   output logic        reg_enable_out,
   output logic [4:0]  rd_addr_out,
   output logic [31:0] rd_data_out,
   output logic [31:0] busy_out
);

   localparam logic [1:0] Full = 2'(QDEPTH);

   logic [1:0]  count_q, count_d;
   logic        wr_ptr_q, rd_ptr_q;
   logic [4:0]  fifo_rd_q   [2];
   logic [31:0] fifo_data_q [2];
   logic [31:0] busy_q, busy_d;
   logic        pipe_win, fifo_pop, fifo_push, busy_set;
   logic [4:0]  head_rd;
   logic [31:0] head_data;

   assign head_rd   = fifo_rd_q[rd_ptr_q];
   assign head_data = fifo_data_q[rd_ptr_q];
   assign busy_out  = busy_q;

   always_comb begin
      pipe_win  = pipe_valid_in && (pipe_rd_addr_in != 5'd0);
      fifo_pop  = !pipe_win && (count_q != 2'd0);
      // A full queue can still accept when its head leaves this cycle.
      lu_ready_out = reset && ((count_q < Full) || fifo_pop);
      fifo_push = lu_valid_in && lu_ready_out && (lu_rd_addr_in != 5'd0);

      hazard_stall_out = reset &&
                         ((busy_q[rs1_addr_in] && (rs1_addr_in != 5'd0)) ||
                          (busy_q[rs2_addr_in] && (rs2_addr_in != 5'd0)) ||
                          (issue_valid_in && busy_q[issue_rd_addr_in] &&
                           (issue_rd_addr_in != 5'd0)));
      busy_set = issue_valid_in && issue_long_in && !hazard_stall_out &&
                 (issue_rd_addr_in != 5'd0);

      count_d = count_q + 2'(fifo_push) - 2'(fifo_pop);

      // Set is applied after clear so a re-issue to the retiring register stays busy.
      busy_d = busy_q;
      if (fifo_pop) busy_d[head_rd] = 1'b0;
      if (busy_set) busy_d[issue_rd_addr_in] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q        <= 2'd0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         busy_q         <= 32'd0;
         reg_enable_out <= 1'b0;
         rd_addr_out    <= 5'd0;
         rd_data_out    <= 32'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_rd_q[i]   <= 5'd0;
            fifo_data_q[i] <= 32'd0;
         end
      end else begin
         count_q <= count_d;
         busy_q  <= busy_d;
         if (fifo_push) begin
            fifo_rd_q[wr_ptr_q]   <= lu_rd_addr_in;
            fifo_data_q[wr_ptr_q] <= lu_rd_data_in;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;

         if (pipe_win) begin
            reg_enable_out <= 1'b1;
            rd_addr_out    <= pipe_rd_addr_in;
            rd_data_out    <= pipe_rd_data_in;
         end else if (fifo_pop) begin
            reg_enable_out <= 1'b1;
            rd_addr_out    <= head_rd;
            rd_data_out    <= head_data;
         end else begin
            reg_enable_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a reference model predicts every write-port cycle into a
// scoreboard queue, a monitor pops and compares; scenario tasks check ready/stall/busy inline.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_valid_in;
   logic [4:0]  pipe_rd_addr_in;
   logic [31:0] pipe_rd_data_in;
   logic        lu_valid_in;
   logic [4:0]  lu_rd_addr_in;
   logic [31:0] lu_rd_data_in;
   logic        lu_ready_out;
   logic        issue_valid_in;
   logic        issue_long_in;
   logic [4:0]  issue_rd_addr_in;
   logic [4:0]  rs1_addr_in;
   logic [4:0]  rs2_addr_in;
   logic        hazard_stall_out;
   logic        reg_enable_out;
   logic [4:0]  rd_addr_out;
   logic [31:0] rd_data_out;
   logic [31:0] busy_out;

   int checks = 0;
   int errors = 0;

   // {enable, addr, data} expected after each edge; model FIFO holds {addr, data}
   logic [37:0] exp_q [$];
   logic [36:0] mq    [$];
   logic [4:0]  last_a = 5'd0;
   logic [31:0] last_d = 32'd0;

   always #5 clk = ~clk;

   wb_arbiter #(.QDEPTH(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .pipe_valid_in    (pipe_valid_in),
      .pipe_rd_addr_in  (pipe_rd_addr_in),
      .pipe_rd_data_in  (pipe_rd_data_in),
      .lu_valid_in      (lu_valid_in),
      .lu_rd_addr_in    (lu_rd_addr_in),
      .lu_rd_data_in    (lu_rd_data_in),
      .lu_ready_out     (lu_ready_out),
      .issue_valid_in   (issue_valid_in),
      .issue_long_in    (issue_long_in),
      .issue_rd_addr_in (issue_rd_addr_in),
      .rs1_addr_in      (rs1_addr_in),
      .rs2_addr_in      (rs2_addr_in),
      .hazard_stall_out (hazard_stall_out),
      .reg_enable_out   (reg_enable_out),
      .rd_addr_out      (rd_addr_out),
      .rd_data_out      (rd_data_out),
      .busy_out         (busy_out)
   );

   // Predict this cycle's write-port result from current inputs, then advance one edge.
   task automatic step();
      logic        en;
      logic [4:0]  a;
      logic [31:0] d;
      logic [36:0] e;
      bit          pop, rdy;
      int          sz;
      en = 1'b0; a = last_a; d = last_d; pop = 0;
      if (!reset) begin
         mq.delete();
         a = 5'd0; d = 32'd0;
      end else begin
         sz = mq.size();
         if (pipe_valid_in && pipe_rd_addr_in != 5'd0) begin
            en = 1'b1; a = pipe_rd_addr_in; d = pipe_rd_data_in;
         end else if (sz > 0) begin
            e = mq.pop_front();
            en = 1'b1; a = e[36:32]; d = e[31:0]; pop = 1;
         end
         rdy = (sz < 2) || pop;
         if (lu_valid_in && rdy && lu_rd_addr_in != 5'd0)
            mq.push_back({lu_rd_addr_in, lu_rd_data_in});
      end
      last_a = a; last_d = d;
      exp_q.push_back({en, a, d});
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      logic [37:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({reg_enable_out, rd_addr_out, rd_data_out} !== e) begin
            errors++;
            $display("FAIL wr_port: got en=%0b rd=%0d data=%h, want en=%0b rd=%0d data=%h",
                     reg_enable_out, rd_addr_out, rd_data_out, e[37], e[36:32], e[31:0]);
         end
      end
   end

   task automatic idle_inputs();
      pipe_valid_in = 0; pipe_rd_addr_in = 0; pipe_rd_data_in = 0;
      lu_valid_in = 0; lu_rd_addr_in = 0; lu_rd_data_in = 0;
      issue_valid_in = 0; issue_long_in = 0; issue_rd_addr_in = 0;
      rs1_addr_in = 0; rs2_addr_in = 0;
   endtask

   task automatic test_reset();
      reset = 0;
      pipe_valid_in = 1; pipe_rd_addr_in = 5; pipe_rd_data_in = 32'hAAAA5555;
      lu_valid_in = 1; lu_rd_addr_in = 6; lu_rd_data_in = 32'h66;
      issue_valid_in = 1; issue_long_in = 1; issue_rd_addr_in = 3;
      rs1_addr_in = 3; rs2_addr_in = 6;
      repeat (3) step();
      checks++;
      if (lu_ready_out !== 1'b0 || hazard_stall_out !== 1'b0 || busy_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_hold: ready=%b stall=%b busy=%h, want 0 0 0",
                  lu_ready_out, hazard_stall_out, busy_out);
      end
      idle_inputs();
      reset = 1;
      #1;
      checks++;
      if (lu_ready_out !== 1'b1 || busy_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_release: ready=%b busy=%h, want 1 0", lu_ready_out, busy_out);
      end
      step();
   endtask

   task automatic test_pipe();
      pipe_valid_in = 1; pipe_rd_addr_in = 5; pipe_rd_data_in = 32'hDEADBEEF;
      step();
      checks++;
      if (reg_enable_out !== 1'b1 || rd_addr_out !== 5'd5 || rd_data_out !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL pipe_write: en=%b rd=%0d data=%h, want 1 5 deadbeef",
                  reg_enable_out, rd_addr_out, rd_data_out);
      end
      pipe_rd_addr_in = 0; pipe_rd_data_in = 32'h12345678;
      step();
      checks++;
      if (reg_enable_out !== 1'b0 || rd_addr_out !== 5'd5) begin
         errors++;
         $display("FAIL pipe_x0: en=%b rd=%0d, want 0 5", reg_enable_out, rd_addr_out);
      end
      idle_inputs();
   endtask

   task automatic test_long();
      issue_valid_in = 1; issue_long_in = 1; issue_rd_addr_in = 7;
      step();
      idle_inputs();
      rs1_addr_in = 7;
      #1;
      checks++;
      if (busy_out[7] !== 1'b1 || hazard_stall_out !== 1'b1) begin
         errors++;
         $display("FAIL long_issue: busy7=%b stall=%b, want 1 1", busy_out[7], hazard_stall_out);
      end
      lu_valid_in = 1; lu_rd_addr_in = 7; lu_rd_data_in = 32'h1234;
      step();
      lu_valid_in = 0;
      checks++;
      if (reg_enable_out !== 1'b0 || busy_out[7] !== 1'b1 || hazard_stall_out !== 1'b1) begin
         errors++;
         $display("FAIL long_n1: en=%b busy7=%b stall=%b, want 0 1 1",
                  reg_enable_out, busy_out[7], hazard_stall_out);
      end
      step();
      checks++;
      if (reg_enable_out !== 1'b1 || rd_addr_out !== 5'd7 || rd_data_out !== 32'h1234 ||
          busy_out[7] !== 1'b0 || hazard_stall_out !== 1'b0) begin
         errors++;
         $display("FAIL long_n2: en=%b rd=%0d data=%h busy7=%b stall=%b, want 1 7 1234 0 0",
                  reg_enable_out, rd_addr_out, rd_data_out, busy_out[7], hazard_stall_out);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_backpressure();
      pipe_valid_in = 1; pipe_rd_addr_in = 1; pipe_rd_data_in = 32'h11;
      lu_valid_in = 1; lu_rd_addr_in = 2; lu_rd_data_in = 32'h22;
      step();
      lu_rd_addr_in = 3; lu_rd_data_in = 32'h33;
      checks++;
      if (lu_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL bp_one_held: ready=%b, want 1", lu_ready_out);
      end
      step();
      lu_rd_addr_in = 4; lu_rd_data_in = 32'h44;
      pipe_rd_data_in = 32'h111;
      #1;
      checks++;
      if (lu_ready_out !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: ready=%b, want 0", lu_ready_out);
      end
      step();
      step();
      lu_valid_in = 0;
      pipe_valid_in = 0;
      #1;
      checks++;
      if (lu_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL bp_pop_ready: ready=%b, want 1", lu_ready_out);
      end
      repeat (3) step();
      idle_inputs();
   endtask

   task automatic test_full_push_pop();
      pipe_valid_in = 1; pipe_rd_addr_in = 1; pipe_rd_data_in = 32'hA1;
      lu_valid_in = 1; lu_rd_addr_in = 10; lu_rd_data_in = 32'hA10;
      step();
      lu_rd_addr_in = 11; lu_rd_data_in = 32'hA11;
      step();
      pipe_valid_in = 0;
      lu_rd_addr_in = 12; lu_rd_data_in = 32'hA12;
      #1;
      checks++;
      if (lu_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL full_pushpop_ready: ready=%b, want 1", lu_ready_out);
      end
      step();
      lu_valid_in = 0;
      pipe_valid_in = 1; pipe_rd_data_in = 32'hA2;
      #1;
      checks++;
      if (lu_ready_out !== 1'b0) begin
         errors++;
         $display("FAIL full_count_kept: ready=%b, want 0", lu_ready_out);
      end
      step();
      pipe_valid_in = 0;
      repeat (3) step();
      idle_inputs();
   endtask

   task automatic test_busy_boundaries();
      // LU result to x9 with no prior issue; re-issue x9 in its pop cycle
      lu_valid_in = 1; lu_rd_addr_in = 9; lu_rd_data_in = 32'h99;
      step();
      lu_valid_in = 0;
      issue_valid_in = 1; issue_long_in = 1; issue_rd_addr_in = 9;
      step();
      issue_valid_in = 0;
      checks++;
      if (reg_enable_out !== 1'b1 || rd_addr_out !== 5'd9 || busy_out[9] !== 1'b1) begin
         errors++;
         $display("FAIL set_wins: en=%b rd=%0d busy9=%b, want 1 9 1",
                  reg_enable_out, rd_addr_out, busy_out[9]);
      end
      issue_valid_in = 1; issue_rd_addr_in = 9;
      #1;
      checks++;
      if (hazard_stall_out !== 1'b1) begin
         errors++;
         $display("FAIL waw_stall: stall=%b, want 1", hazard_stall_out);
      end
      issue_rd_addr_in = 12; rs2_addr_in = 9;
      step();
      issue_valid_in = 0; rs2_addr_in = 0;
      checks++;
      if (busy_out[12] !== 1'b0 || busy_out[9] !== 1'b1 || busy_out[0] !== 1'b0) begin
         errors++;
         $display("FAIL stalled_issue: busy=%h, want bit9 only", busy_out);
      end
      lu_valid_in = 1; lu_rd_addr_in = 9; lu_rd_data_in = 32'h999;
      step();
      idle_inputs();
      repeat (2) step();
   endtask

   task automatic test_reset_queued();
      pipe_valid_in = 1; pipe_rd_addr_in = 1; pipe_rd_data_in = 32'hB1;
      lu_valid_in = 1; lu_rd_addr_in = 20; lu_rd_data_in = 32'hB20;
      issue_valid_in = 1; issue_long_in = 1; issue_rd_addr_in = 21;
      step();
      issue_valid_in = 0;
      lu_rd_addr_in = 21; lu_rd_data_in = 32'hB21;
      step();
      idle_inputs();
      reset = 0;
      step();
      reset = 1;
      #1;
      checks++;
      if (busy_out !== 32'd0 || lu_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_queued: busy=%h ready=%b, want 0 1", busy_out, lu_ready_out);
      end
      repeat (3) step();
   endtask

   initial begin
      idle_inputs();
      reset = 0;
      test_reset();
      test_pipe();
      test_long();
      test_backpressure();
      test_full_push_pop();
      test_busy_boundaries();
      test_reset_queued();
      #20;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and scoreboard for the register file's single write port. It merges single-cycle pipeline results with results from the long-latency unit (mul/div, uncached load), queueing the latter in a 2-entry FIFO. It tracks registers whose long-latency writes are still outstanding and raises a hazard stall toward ID. It sits between EX/MEM/LU and the register file write port (`ex_reg_enable`, `rd_addr`, `rd_data`).

## Interface
- `QDEPTH`, 2: long-unit result FIFO depth; only 2 is supported, with a 1-bit pointer per side.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising edge of `clk`.
- `pipe_valid_in` in 1: pipeline result valid this cycle; cannot be back-pressured.
- `pipe_rd_addr_in` in 5: pipeline destination register.
- `pipe_rd_data_in` in 32: pipeline result.
- `lu_valid_in` in 1: long-unit result valid.
- `lu_rd_addr_in` in 5: long-unit destination register.
- `lu_rd_data_in` in 32: long-unit result.
- `lu_ready_out` out 1: FIFO can accept; a transfer occurs when valid && ready.
- `issue_valid_in` in 1: ID issues an instruction this cycle.
- `issue_long_in` in 1: issued instruction completes through the long unit.
- `issue_rd_addr_in` in 5: issued instruction destination.
- `rs1_addr_in`, `rs2_addr_in` in 5 each: ID source registers.
- `hazard_stall_out` out 1: combinational; ID must hold.
- `reg_enable_out` out 1: registered write enable to the register file.
- `rd_addr_out` out 5: registered write address.
- `rd_data_out` out 32: registered write data.
- `busy_out` out 32: scoreboard; bit n is set while a long write to xn is outstanding; bit 0 is always 0.

## Operation
- **Reset** (`reset`=0 at edge):
  - FIFO count is 0 and pointers are 0.
  - `busy_out`=0.
  - `reg_enable_out`=0, `rd_addr_out`=0, `rd_data_out`=0.
  - While `reset`=0, `lu_ready_out`=0 and `hazard_stall_out`=0.
- **Port arbitration** (one winner per cycle, registered onto the outputs at the next edge):
  1. If `pipe_valid_in` and `pipe_rd_addr_in`≠0, the pipeline wins. The FIFO holds.
  2. Otherwise, if the FIFO is non-empty, the FIFO head wins and is popped. `busy[head.rd]` clears at the same edge.
  3. Otherwise `reg_enable_out`=0. `rd_addr_out` and `rd_data_out` hold their previous values.
- **Pipeline writes to x0** are treated as idle, so the FIFO may drain that cycle.
- **FIFO push:**
  - Occurs when `lu_valid_in` && `lu_ready_out` && `lu_rd_addr_in`≠0.
  - When `lu_rd_addr_in`=0, the handshake completes but the result is discarded. There is no push and no busy change.
- **`lu_ready_out`** = (count<2) OR (count==2 AND a FIFO pop occurs this cycle). Push and pop in the same cycle leave the count unchanged.
- **Empty FIFO:** a pushed entry is not bypassed to the port in the same cycle. The earliest write is on the edge after the push cycle plus one, i.e. two edges after the handshake.
- **Scoreboard set:** occurs when `issue_valid_in` && `issue_long_in` && !`hazard_stall_out` && `issue_rd_addr_in`≠0.
  - If the same register is cleared and set in one cycle, the set wins and the bit ends at 1.
  - `issue_valid_in` while `hazard_stall_out`=1 is ignored.
- **Stall:** `hazard_stall_out` = (`busy[rs1]` && rs1≠0) OR (`busy[rs2]` && rs2≠0) OR (`issue_valid_in` && `busy[issue_rd]` && issue_rd≠0).
  - The last term is the WAW check.
  - Stall evaluation uses registered busy, so a register being written this edge still stalls for one more cycle.
- **Pipeline result to a busy register** is a protocol violation and is prevented by the stall. No check is performed.

## Timing
- Pipeline result: `reg_enable_out` rises at edge N+1 for `pipe_valid_in` in cycle N. Latency is 1.
- Long result accepted in cycle N with the port free: written at edge N+2, and busy clears at that same edge.
- Continuous pipeline traffic starves the FIFO indefinitely; `lu_ready_out` falls once 2 entries are held.
- FIFO order is strict FIFO, with no reordering between entries.
- `reset` asserted mid-operation discards queued entries and clears busy. In-flight handshakes in that cycle are lost.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with all inputs active → all outputs 0, `lu_ready_out`=0; after release, `lu_ready_out`=1 and `busy_out`=0.
- **Pipeline path:** `pipe_valid_in`=1, rd=5, data=0xDEADBEEF in cycle N → `reg_enable_out`=1, `rd_addr_out`=5, `rd_data_out`=0xDEADBEEF after edge N+1. Same stimulus with rd=0 → `reg_enable_out`=0.
- **Long path with scoreboard:**
  - Issue long rd=7 → `busy_out[7]`=1.
  - ID with rs1=7 → `hazard_stall_out`=1.
  - LU returns rd=7, 0x1234 → written two edges later; busy[7]=0 at that edge; stall drops the following cycle.
- **Backpressure:**
  - Pipeline valid every cycle to rd=1; push LU results to rd=2,3 → `lu_ready_out`=0 after 2 pushes.
  - Drop the pipeline → x2 written, then x3, in order; ready reasserts in the first pop cycle.
- **Boundaries:**
  - Full FIFO with simultaneous push and pop → count stays 2 with the new entry last.
  - Issue long rd=9 in the same cycle busy[9] clears → busy[9]=1.
  - WAW: issue rd=9 while busy[9] → stall, no set.
  - Reset with 2 queued entries → queue empty, no writes after release.
